serial_sub_ctrl: RTL and testbench

- Bit-serial subtraction controller. Accepts two WIDTH-bit operands and a borrow-in over a valid/ready handshake.
- Sequences one internal 1-bit full-subtractor cell (D = a^b^Bin; Bout = (~a&b) | (~(a^b)&Bin)) LSB-first across WIDTH cycles. The borrow is registered between bit slots.
- Returns the WIDTH-bit difference and final borrow over a second valid/ready handshake.
- Used where area matters more than latency: shared datapath slices, low-rate counters/comparators.

---
 rtl/serial_sub_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor controller.
// Accepts a, b, Bin over a valid/ready handshake, runs one 1-bit full-subtractor
// cell LSB-first for WIDTH cycles with a registered borrow, then presents the
// WIDTH-bit difference and final borrow over a second valid/ready handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered two's-complement
// overflow flag V.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last_bit;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic             brw;
   logic             cell_d;
   logic             cell_bout;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
   logic             v_q;

   assign V = v_q;
`endif

   // Shared 1-bit full-subtractor cell and the right-shifting result word.
   always_comb begin
      cell_d    = a_sr[0] ^ b_sr[0] ^ brw;
      cell_bout = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
      res_nxt   = res_sr >> 1;
      res_nxt[WIDTH-1] = cell_d;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic, handshake outputs and datapath strobes.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               last_bit  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, per-bit shifting, and result/borrow hold registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         brw    <= 1'b0;
         D      <= '0;
         Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         v_q    <= 1'b0;
`endif
      end else if (accept) begin
         cnt    <= '0;
         a_sr   <= a;
         b_sr   <= b;
         brw    <= Bin;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         cnt    <= cnt + 1'b1;
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_nxt;
         brw    <= cell_bout;
         if (last_bit) begin
            // The final slot's bit is the MSB, so the full word is res_nxt.
            D    <= res_nxt;
            Bout <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
            v_q  <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// Define SERIAL_SUB_OVF_EN to also exercise the overflow flag V.
module tb_serial_sub_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             Bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] D;
   logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             V;
`endif

   int vectors;
   int miscompares;

   serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bout      (Bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .V         (V)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports mismatches.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for out_valid; returns cycles counted from the acceptance cycle.
   task automatic wait_valid(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
   endtask

   // One complete transaction with hand-computed expectations.
   task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] exp_d, input logic exp_b);
      int lat;
      @(negedge clk);
      a = av; b = bv; Bin = bi; in_valid = 1'b1;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      wait_valid(lat);
      in_valid = 1'b0;
      check({tag, "_latency"}, lat, 9);
      check({tag, "_D"}, D, exp_d);
      check({tag, "_Bout"}, Bout, exp_b);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ov_after_hs"}, out_valid, 1'b0);
   endtask

   int acc_cyc [3];
   logic [7:0] set_a [3];
   logic [7:0] set_b [3];
   logic       set_bi [3];
   logic [7:0] exp_dv [3];
   logic       exp_bv [3];

   initial begin
      int lat;
      int idx_in;
      int idx_out;
      bit pending;
      logic [7:0] d_hold;
      logic       b_hold;

      vectors = 0; miscompares = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; Bin = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_D", D, 8'h00);
      check("rst_Bout", Bout, 1'b0);
      rst = 1'b0;

      // Case 1 and 2: basic subtraction, wrap and borrow
      do_op("c1", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
      do_op("c2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      do_op("c2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      do_op("c2c", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

      // Case 3: in_valid pulses during RUN/DONE are ignored; backpressure holds output
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; Bin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 8'h99; b = 8'h01; Bin = 1'b1;
      check("c3_in_ready_run", in_ready, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      lat = 3;
      while (!out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      check("c3_latency", lat, 9);
      d_hold = D; b_hold = Bout;
      check("c3_D", D, 8'h1E);
      check("c3_Bout", Bout, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check("c3_hold_ov", out_valid, 1'b1);
         check("c3_hold_ir", in_ready, 1'b0);
         check("c3_hold_D", D, d_hold);
         check("c3_hold_B", Bout, b_hold);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("c3_ov_after_hs", out_valid, 1'b0);
      check("c3_ir_after_hs", in_ready, 1'b1);
      check("c3_D_kept", D, 8'h1E);

      // Case 4: reset on the 4th RUN cycle aborts the operation
      a = 8'hAA; b = 8'h55; Bin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("c4_ov", out_valid, 1'b0);
      check("c4_ir", in_ready, 1'b1);
      check("c4_D", D, 8'h00);
      check("c4_Bout", Bout, 1'b0);
      repeat (12) begin
         @(negedge clk);
         if (out_valid) check("c4_spurious_ov", out_valid, 1'b0);
      end
      do_op("c4b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

      // Case 5: back-to-back with in_valid and out_ready held high
      set_a[0] = 8'h35; set_b[0] = 8'h12; set_bi[0] = 1'b0; exp_dv[0] = 8'h23; exp_bv[0] = 1'b0;
      set_a[1] = 8'h10; set_b[1] = 8'h20; set_bi[1] = 1'b0; exp_dv[1] = 8'hF0; exp_bv[1] = 1'b1;
      set_a[2] = 8'h80; set_b[2] = 8'h7F; set_bi[2] = 1'b1; exp_dv[2] = 8'h00; exp_bv[2] = 1'b0;
      idx_in = 0; idx_out = 0; pending = 1'b0;
      @(negedge clk);
      a = set_a[0]; b = set_b[0]; Bin = set_bi[0];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 80 && idx_out < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (pending) begin
            pending = 1'b0;
            if (idx_in < 3) begin
               a = set_a[idx_in]; b = set_b[idx_in]; Bin = set_bi[idx_in];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            check("c5_D", D, exp_dv[idx_out]);
            check("c5_Bout", Bout, exp_bv[idx_out]);
            idx_out++;
         end
         if (in_valid && in_ready && idx_in < 3) begin
            acc_cyc[idx_in] = c;
            idx_in++;
            pending = 1'b1;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("c5_results", idx_out, 3);
      check("c5_accepts", idx_in, 3);
      if (idx_in == 3) begin
         check("c5_space01", acc_cyc[1] - acc_cyc[0], 10);
         check("c5_space12", acc_cyc[2] - acc_cyc[1], 10);
      end
      repeat (2) @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
      // Case 6: overflow flag
      do_op("c6a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
      check("c6a_V", V, 1'b1);
      do_op("c6b", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0);
      check("c6b_V", V, 1'b0);
      do_op("c6c", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
      check("c6c_V", V, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
